// File: rtl/phase_mem_sequencer.sv
// Sequencer that runs the enabled phase blocks one at a time in index order,
// muxing the active phase's bus onto the single-port node memory.
`timescale 1ns/1ps
module phase_mem_sequencer #(
    parameter int N_PHASES    = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clock,
    input  logic                       nrst,
    input  logic                       run_i,
    input  logic [N_PHASES-1:0]        phase_en_i,
    input  logic [N_PHASES*ADDR_W-1:0] ph_addr_i,
    input  logic [N_PHASES-1:0]        ph_wr_en_i,
    input  logic [N_PHASES*DATA_W-1:0] ph_wdata_i,
    input  logic [N_PHASES-1:0]        ph_done_i,
    output logic [N_PHASES-1:0]        ph_start_o,
    output logic [N_PHASES-1:0]        ph_nrst_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic                       mem_wr_en_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [2:0]                 cur_phase_o
);

    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, FIN, ERR} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [N_PHASES-1:0] mask_q, mask_d;
    logic [2:0]          cur_phase_q, cur_phase_d;
    logic [N_PHASES-1:0] ph_nrst_q, ph_nrst_d;
    logic [N_PHASES-1:0] ph_start_q, ph_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [15:0]         timer_q, timer_d;

    logic [N_PHASES-1:0] curBit;
    logic [2:0]          firstIdx;
    logic                nextValid;
    logic [2:0]          nextIdx;

    function automatic logic [N_PHASES-1:0] phaseBit(input logic [2:0] idx);
        logic [N_PHASES-1:0] b;
        for (int i = 0; i < N_PHASES; i++) begin
            b[i] = (idx == 3'(i));
        end
        return b;
    endfunction

    // Lowest enabled phase of a new request, and next enabled phase above the current one.
    always_comb begin
        curBit    = phaseBit(cur_phase_q);
        firstIdx  = '0;
        nextValid = 1'b0;
        nextIdx   = '0;
        for (int i = N_PHASES - 1; i >= 0; i--) begin
            if (phase_en_i[i]) begin
                firstIdx = 3'(i);
            end
            if (mask_q[i] && (i > int'(cur_phase_q))) begin
                nextValid = 1'b1;
                nextIdx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_phase_d = cur_phase_q;
        ph_nrst_d   = ph_nrst_q;
        ph_start_d  = '0;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE, ERR: begin
                // A faulted phase stays in reset until a new run is accepted.
                if (state_q == IDLE) begin
                    ph_nrst_d = '1;
                end
                if (run_i) begin
                    mask_d    = phase_en_i;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    ph_nrst_d = '1;
                    if (phase_en_i != '0) begin
                        cur_phase_d = firstIdx;
                        ph_nrst_d   = ~phaseBit(firstIdx);
                        busy_d      = 1'b1;
                        state_d     = CLR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            CLR: begin
                ph_nrst_d  = ph_nrst_q | curBit;
                ph_start_d = curBit;
                state_d    = START;
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if ((ph_done_i & curBit) != '0) begin
                    if (nextValid) begin
                        cur_phase_d = nextIdx;
                        ph_nrst_d   = ph_nrst_q & ~phaseBit(nextIdx);
                        state_d     = CLR;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end else if ((TIMEOUT_CYC != 0) && (timer_q == TMO_LAST)) begin
                    ph_nrst_d = ph_nrst_q & ~curBit;
                    error_d   = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ERR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cur_phase_q <= '0;
            ph_nrst_q   <= '0;
            ph_start_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_phase_q <= cur_phase_d;
            ph_nrst_q   <= ph_nrst_d;
            ph_start_q  <= ph_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            timer_q     <= timer_d;
        end
    end

    // Writes from a phase still held in reset must never reach the memory.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wr_en_o = 1'b0;
        if ((state_q == CLR) || (state_q == START) || (state_q == WAIT)) begin
            for (int i = 0; i < N_PHASES; i++) begin
                if (curBit[i]) begin
                    mem_addr_o  = ph_addr_i[i*ADDR_W +: ADDR_W];
                    mem_wdata_o = ph_wdata_i[i*DATA_W +: DATA_W];
                    mem_wr_en_o = ph_wr_en_i[i] & ph_nrst_q[i];
                end
            end
        end
    end

    assign ph_start_o  = ph_start_q;
    assign ph_nrst_o   = ph_nrst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign cur_phase_o = cur_phase_q;

endmodule

// File: tb/tb_phase_mem_sequencer.sv
// Directed bench for phase_mem_sequencer with behavioural stub phases that
// assert a sticky done a fixed number of cycles after their start pulse.
`timescale 1ns/1ps
module tb_phase_mem_sequencer;

    localparam int NP = 4;

    logic          clock = 1'b0;
    logic          nrst = 1'b0;
    logic          run = 1'b0;
    logic [NP-1:0] phase_en = '0;
    logic [63:0]   ph_addr = '0;
    logic [NP-1:0] ph_wr_en = '0;
    logic [63:0]   ph_wdata = '0;
    logic [NP-1:0] ph_done;
    logic [NP-1:0] ph_start;
    logic [NP-1:0] ph_nrst;
    logic [15:0]   mem_addr;
    logic          mem_wr_en;
    logic [15:0]   mem_wdata;
    logic          busy_o, done_o, error_o;
    logic [2:0]    cur_phase;

    int testsRun = 0;
    int testsFailed = 0;

    logic [NP-1:0] stubDone = '0;
    logic [NP-1:0] stubActive = '0;
    logic [NP-1:0] stubHang = '0;
    int stubCnt[NP];
    int stubDelay[NP];
    int startCnt[NP];
    int nrstLowCnt[NP];
    int goodWr = 0;
    int badWr = 0;
    int baseStart[NP];
    int baseLow[NP];
    int baseGood, baseBad;

    assign ph_done = stubDone;

    phase_mem_sequencer #(.N_PHASES(NP), .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(16)) dut (
        .clock(clock), .nrst(nrst), .run_i(run), .phase_en_i(phase_en),
        .ph_addr_i(ph_addr), .ph_wr_en_i(ph_wr_en), .ph_wdata_i(ph_wdata),
        .ph_done_i(ph_done), .ph_start_o(ph_start), .ph_nrst_o(ph_nrst),
        .mem_addr_o(mem_addr), .mem_wr_en_o(mem_wr_en), .mem_wdata_o(mem_wdata),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .cur_phase_o(cur_phase)
    );

    always #5 clock = ~clock;

    // Stub phases plus start-pulse and reset-cycle counters per phase.
    initial begin
        for (int i = 0; i < NP; i++) begin
            stubCnt[i] = 0; startCnt[i] = 0; nrstLowCnt[i] = 0; stubDelay[i] = 5;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < NP; i++) begin
            if (ph_start[i]) startCnt[i] <= startCnt[i] + 1;
            if (!ph_nrst[i]) nrstLowCnt[i] <= nrstLowCnt[i] + 1;
            if (!ph_nrst[i]) begin
                stubDone[i] <= 1'b0; stubActive[i] <= 1'b0; stubCnt[i] <= 0;
            end else if (ph_start[i]) begin
                stubActive[i] <= 1'b1; stubCnt[i] <= 1;
            end else if (stubActive[i] && !stubHang[i] && !stubDone[i]) begin
                if (stubCnt[i] >= stubDelay[i]) stubDone[i] <= 1'b1;
                else stubCnt[i] <= stubCnt[i] + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (mem_wr_en) begin
            if (mem_addr == 16'h068E && mem_wdata == 16'h0003) goodWr <= goodWr + 1;
            else badWr <= badWr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NP-1:0] en);
        @(negedge clock);
        run = 1'b1; phase_en = en;
        @(negedge clock);
        run = 1'b0;
    endtask

    task automatic waitEnd(input string tag, input int budget);
        int n = 0;
        while (!(done_o || error_o) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!(done_o || error_o)) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic snapshot();
        for (int i = 0; i < NP; i++) begin
            baseStart[i] = startCnt[i]; baseLow[i] = nrstLowCnt[i];
        end
        baseGood = goodWr; baseBad = badWr;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 32'(busy_o), 0);
        checkOutput("rst_done", 32'(done_o), 0);
        checkOutput("rst_error", 32'(error_o), 0);
        checkOutput("rst_ph_nrst", 32'(ph_nrst), 0);
        checkOutput("rst_ph_start", 32'(ph_start), 0);
        checkOutput("rst_cur_phase", 32'(cur_phase), 0);
        checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 0);
        nrst = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("idle_ph_nrst", 32'(ph_nrst), 32'hF);

        // Empty mask finishes straight from IDLE.
        snapshot();
        checkOutput("empty_done_before", 32'(done_o), 0);
        applyStimulus(4'b0000);
        checkOutput("empty_done", 32'(done_o), 1);
        checkOutput("empty_busy", 32'(busy_o), 0);
        checkOutput("empty_wr_en", 32'(mem_wr_en), 0);
        repeat (2) @(negedge clock);
        checkOutput("empty_starts", 32'(startCnt[0] + startCnt[1] + startCnt[2] + startCnt[3]
                    - baseStart[0] - baseStart[1] - baseStart[2] - baseStart[3]), 0);

        // Phases 0 and 2 only.
        snapshot();
        applyStimulus(4'b0101);
        checkOutput("seq_busy_run", 32'(busy_o), 1);
        checkOutput("seq_done_clr", 32'(done_o), 0);
        waitEnd("seq", 200);
        checkOutput("seq_done", 32'(done_o), 1);
        checkOutput("seq_busy", 32'(busy_o), 0);
        checkOutput("seq_error", 32'(error_o), 0);
        checkOutput("seq_cur_phase", 32'(cur_phase), 2);
        for (int i = 0; i < NP; i++) begin
            checkOutput($sformatf("seq_start%0d", i), 32'(startCnt[i] - baseStart[i]), (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("seq_nrstlow%0d", i), 32'(nrstLowCnt[i] - baseLow[i]), (i % 2 == 0) ? 1 : 0);
        end

        // Memory mux: phase 0 writes, phase 3 also drives a write.
        ph_addr = {16'h1234, 16'h0000, 16'h0000, 16'h068E};
        ph_wdata = {16'hBEEF, 16'h0000, 16'h0000, 16'h0003};
        ph_wr_en = 4'b1001;
        snapshot();
        applyStimulus(4'b0001);
        checkOutput("mux_clr_addr", 32'(mem_addr), 32'h068E);
        checkOutput("mux_clr_wr_gated", 32'(mem_wr_en), 0);
        @(negedge clock);
        checkOutput("mux_start_wr", 32'(mem_wr_en), 1);
        checkOutput("mux_start_data", 32'(mem_wdata), 32'h0003);
        waitEnd("mux", 200);
        checkOutput("mux_good_writes", 32'(goodWr - baseGood > 0), 1);
        checkOutput("mux_bad_writes", 32'(badWr - baseBad), 0);
        checkOutput("mux_idle_addr", 32'(mem_addr), 0);
        ph_wr_en = '0;

        // Watchdog on hung phase 1.
        stubHang[1] = 1'b1;
        snapshot();
        applyStimulus(4'b0111);
        waitEnd("wdog", 300);
        checkOutput("wdog_error", 32'(error_o), 1);
        checkOutput("wdog_done", 32'(done_o), 1);
        checkOutput("wdog_busy", 32'(busy_o), 0);
        checkOutput("wdog_cur_phase", 32'(cur_phase), 1);
        repeat (4) @(negedge clock);
        checkOutput("wdog_hold_nrst1", 32'(ph_nrst[1]), 0);
        checkOutput("wdog_hold_error", 32'(error_o), 1);
        checkOutput("wdog_start1", 32'(startCnt[1] - baseStart[1]), 1);
        checkOutput("wdog_start2", 32'(startCnt[2] - baseStart[2]), 0);
        stubHang[1] = 1'b0;
        applyStimulus(4'b0010);
        checkOutput("wdog_rerun_error_clr", 32'(error_o), 0);
        waitEnd("wdog_rerun", 200);
        checkOutput("wdog_rerun_done", 32'(done_o), 1);
        checkOutput("wdog_rerun_error", 32'(error_o), 0);

        // Reset during WAIT of phase 2.
        ph_addr = {16'h0000, 16'h0200, 16'h0000, 16'h0000};
        ph_wdata = {16'h0000, 16'h5A5A, 16'h0000, 16'h0000};
        ph_wr_en = 4'b0100;
        stubDelay[2] = 30;
        applyStimulus(4'b0100);
        repeat (5) @(negedge clock);
        checkOutput("mrst_pre_wr_en", 32'(mem_wr_en), 1);
        nrst = 1'b0;
        @(negedge clock);
        checkOutput("mrst_busy", 32'(busy_o), 0);
        checkOutput("mrst_done", 32'(done_o), 0);
        checkOutput("mrst_ph_nrst", 32'(ph_nrst), 0);
        checkOutput("mrst_cur_phase", 32'(cur_phase), 0);
        checkOutput("mrst_wr_en", 32'(mem_wr_en), 0);
        checkOutput("mrst_addr", 32'(mem_addr), 0);
        nrst = 1'b1;
        ph_wr_en = '0;
        stubDelay[2] = 5;
        repeat (2) @(negedge clock);
        applyStimulus(4'b0100);
        waitEnd("mrst_rerun", 200);
        checkOutput("mrst_rerun_done", 32'(done_o), 1);
        checkOutput("mrst_rerun_error", 32'(error_o), 0);

        // Stale sticky done on phase 1 must be cleared before it counts.
        applyStimulus(4'b0010);
        waitEnd("stale_prime", 200);
        checkOutput("stale_prime_done", 32'(ph_done[1]), 1);
        stubDelay[1] = 8;
        snapshot();
        applyStimulus(4'b0010);
        checkOutput("stale_done_clr", 32'(done_o), 0);
        repeat (4) @(negedge clock);
        checkOutput("stale_done_wait", 32'(done_o), 0);
        checkOutput("stale_busy_wait", 32'(busy_o), 1);
        waitEnd("stale", 200);
        checkOutput("stale_done", 32'(done_o), 1);
        checkOutput("stale_start1", 32'(startCnt[1] - baseStart[1]), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
